// File: rtl/if_id_queue_pkg.sv
// Shared constants and types for the IF/ID instruction queue.
package if_id_pkg;

    localparam logic [31:0] NOP_INSN = 32'h00000013;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ra;
    } fetch_entry_t;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: circular buffer, flushed on control-flow redirect.
// Define IF_ID_BYPASS_EN for zero-latency pass-through when the queue is empty.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_ir,
    input  logic [WIDTH-1:0]                in_pc,
    input  logic [WIDTH-1:0]                in_ra,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_ir,
    output logic [WIDTH-1:0]                out_pc,
    output logic [WIDTH-1:0]                out_ra,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] ir;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] ra;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            bypass;

    // Registered-state only, so IF's PC enable never sees ID's stall.
    assign in_ready = (count != CW'(DEPTH));

    always_comb begin
        head      = mem[rd_ptr];
        out_valid = (count != '0) && !flush;
        bypass    = 1'b0;
`ifdef IF_ID_BYPASS_EN
        if ((count == '0) && in_valid && !flush) begin
            bypass    = 1'b1;
            out_valid = 1'b1;
            head      = '{ir: in_ir, pc: in_pc, ra: in_ra};
        end
`endif
        pop    = out_valid && out_ready && !bypass;
        // A bypassed instruction consumed this cycle is never stored.
        push   = in_valid && in_ready && !flush && !(bypass && out_ready);
        out_ir = out_valid ? head.ir : WIDTH'(NOP_INSN);
        out_pc = out_valid ? head.pc : '0;
        out_ra = out_valid ? head.ra : '0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr] <= '{ir: in_ir, pc: in_pc, ra: in_ra};
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (DEPTH=2, WIDTH=32, default build).
module tb_if_id_queue;

    localparam int DEPTH = 2;
    localparam int WIDTH = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_ir, in_pc, in_ra;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_ir, out_pc, out_ra;
    logic [1:0]       count;

    if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_pc(in_pc), .in_ra(in_ra),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ir(out_ir), .out_pc(out_pc), .out_ra(out_ra),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        fl;
        logic        ordy;
        logic [1:0]  cnt;   // expected during this cycle, before the edge
        logic        rdy;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] ra;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return 32'h00500093 ^ {pc[19:0], 12'h000};
    endfunction

    task automatic add(input logic iv, input logic [31:0] pc, input logic fl,
                       input logic ordy, input logic [1:0] cnt, input logic rdy,
                       input logic ov);
        vec_t v;
        v.iv = iv; v.pc = pc; v.fl = fl; v.ordy = ordy;
        v.cnt = cnt; v.rdy = rdy; v.ov = ov;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic fl,
                         input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_ir     = ir_of(pc);
        in_ra     = pc + 32'd4;
        flush     = fl;
        out_ready = ordy;
    endtask

    initial begin
        // Reset state, single push, fill/back-pressure, full+pop, drain, empty pop.
        add(0, 32'h0,  0, 0, 2'd0, 1, 0);
        add(1, 32'h0,  0, 0, 2'd0, 1, 0);
        add(1, 32'h4,  0, 0, 2'd1, 1, 1);
        add(1, 32'h8,  0, 0, 2'd2, 0, 1);
        add(1, 32'h8,  0, 1, 2'd2, 0, 1);
        add(0, 32'h0,  0, 1, 2'd1, 1, 1);
        add(0, 32'h0,  0, 1, 2'd0, 1, 0);
        // Flush from full, redirected push, then back-to-back flushes.
        add(1, 32'h0,  0, 0, 2'd0, 1, 0);
        add(1, 32'h4,  0, 0, 2'd1, 1, 1);
        add(1, 32'h10, 1, 1, 2'd2, 0, 0);
        add(1, 32'h40, 0, 0, 2'd0, 1, 0);
        add(0, 32'h0,  0, 0, 2'd1, 1, 1);
        add(1, 32'h44, 1, 1, 2'd1, 1, 0);
        add(0, 32'h0,  1, 1, 2'd0, 1, 0);
        add(0, 32'h0,  0, 1, 2'd0, 1, 0);
        // Wrap-around: 7 push/pop pairs.
        for (int k = 0; k < 7; k++) begin
            add(1, 32'(4 * k), 0, 0, 2'd0, 1, 0);
            add(0, 32'h0,      0, 1, 2'd1, 1, 1);
        end
        // Simultaneous push and pop with one entry held.
        add(1, 32'h200, 0, 0, 2'd0, 1, 0);
        add(1, 32'h204, 0, 1, 2'd1, 1, 1);
        add(0, 32'h0,   0, 1, 2'd1, 1, 1);
        add(0, 32'h0,   0, 0, 2'd0, 1, 0);

        rst = 1'b1;
        drive(0, 32'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].fl, vecs[i].ordy);
            @(negedge clk);
            chk($sformatf("count[%0d]", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("in_ready[%0d]", i), 32'(in_ready), 32'(vecs[i].rdy));
            chk($sformatf("out_valid[%0d]", i), 32'(out_valid), 32'(vecs[i].ov));
            if (!vecs[i].ov) begin
                chk($sformatf("nop_ir[%0d]", i), out_ir, NOP);
                chk($sformatf("zero_pc[%0d]", i), out_pc, 32'h0);
                chk($sformatf("zero_ra[%0d]", i), out_ra, 32'h0);
            end else if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL head[%0d]: out_valid=1 got pc %h want empty queue", i, out_pc);
            end else begin
                chk($sformatf("head_pc[%0d]", i), out_pc, sbq[0].pc);
                chk($sformatf("head_ir[%0d]", i), out_ir, sbq[0].ir);
                chk($sformatf("head_ra[%0d]", i), out_ra, sbq[0].ra);
                if (vecs[i].ordy)
                    void'(sbq.pop_front());
            end
            if (vecs[i].iv && vecs[i].rdy && !vecs[i].fl) begin
                exp_t e;
                e.pc = vecs[i].pc;
                e.ir = ir_of(vecs[i].pc);
                e.ra = vecs[i].pc + 32'd4;
                sbq.push_back(e);
            end
            if (vecs[i].fl)
                sbq.delete();
            @(posedge clk);
            #1;
        end

        chk("sb_drained", 32'(sbq.size()), 32'd0);

        // Mid-stream reset beats a concurrent push and pop.
        drive(1, 32'h100, 0, 0);
        @(posedge clk); #1;
        drive(1, 32'h104, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1;
        drive(1, 32'h108, 0, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 32'h0, 0, 0);
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ir", out_ir, NOP);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling instruction queue between the fetch stage and the decode stage of the 5-stage RV32 pipeline.
- Accepts fetched {ir, pc, ra} triples from IF and presents them in order to ID.
- Absorbs ID back-pressure without a combinational stall path back to the PC register.
- Discards all wrong-path instructions on a control-flow redirect (branch/jal/jalr taken).

Parameters:
- DEPTH, 2, number of queue entries; power of two, >= 2.
- WIDTH, 32, width of each of ir/pc/ra.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  IF presents a fetched instruction this cycle.
- in_ready  out  1  queue accepts a push this cycle; IF drives its PC enable from this (stall = ~in_ready).
- in_ir  in  WIDTH  fetched instruction word.
- in_pc  in  WIDTH  PC of in_ir.
- in_ra  in  WIDTH  in_pc + 4 (link value).
- flush  in  1  redirect from EX; kills queue contents and the current push.
- out_valid  out  1  head entry valid for ID.
- out_ready  in  1  ID consumes the head this cycle (~ID stall).
- out_ir  out  WIDTH  head instruction; NOP when out_valid = 0.
- out_pc  out  WIDTH  head PC; 0 when out_valid = 0.
- out_ra  out  WIDTH  head link value; 0 when out_valid = 0.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer with wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH) and a registered count.
- Reset (rst high at edge):
  - ptrs = 0, count = 0.
  - Storage contents don't-care.
  - Outputs after reset: out_valid = 0, out_ir = 32'h00000013, out_pc = 0, out_ra = 0, in_ready = 1.
  - rst overrides flush and push/pop.
  - rst mid-stream drops all entries.
- Push: in_valid && in_ready && !flush. The entry is written at wr_ptr and wr_ptr increments.
- Pop: out_valid && out_ready. rd_ptr increments.
- in_ready = (count != DEPTH):
  - Depends only on registered state, never on out_ready.
  - Consequence: when full, a same-cycle pop does not enable a push.
- out_valid = (count != 0) && !flush. Outputs are driven combinationally from entry[rd_ptr], or the NOP/zero values when not valid.
- Latency: an entry pushed at edge N appears at the outputs after edge N (registered, 1 cycle).
- Simultaneous push and pop (not full, not empty): count unchanged; both pointers advance.
- Flush:
  - At the next edge: count = 0, wr_ptr = rd_ptr = 0.
  - In the flush cycle, push and pop are both suppressed, since out_valid is forced 0.
  - The queue is empty the cycle after flush. The redirected instruction fetched in that cycle is pushed normally.
- Full: in_ready = 0. IF must hold pc/ir stable; the queue ignores in_* while in_ready = 0.
- Empty with out_ready = 1: no pop, count stays 0, no underflow.
- Back-to-back flushes: each cycle leaves the queue empty.

Optional Feature:
- Macro: IF_ID_BYPASS_EN.
- Defined:
  - When count == 0 and in_valid && !flush, the in_* values pass straight through to out_* with out_valid = 1 in the same cycle.
  - If out_ready is also 1, the instruction is consumed and not stored (count stays 0).
  - Otherwise it is stored normally.
  - Zero-latency when empty.
- Undefined: strictly 1-cycle latency as above.
- in_ready is unchanged in both modes.

Decomposition:
- Package if_id_pkg:
  - NOP_INSN = 32'h00000013.
  - Packed struct fetch_entry_t {ir, pc, ra}, 3*WIDTH bits.
  - Function for the count width.
- Sub-module: none. Storage, pointer logic and output muxing fit in one module (roughly 150 lines).

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, out_ir=0x00000013, count=0, in_ready=1.
- Single push: in_valid=1, ir=0x00500093, pc=0x0, ra=0x4 with out_ready=0.
  - Next cycle: out_valid=1, out_ir=0x00500093, out_ra=0x4, count=1.
  - Bypass build: valid in the same cycle.
- Fill and back-pressure (DEPTH=2): push pc=0x0, then 0x4, with out_ready=0.
  - count=2, in_ready=0.
  - A third in_valid with pc=0x8 is not stored.
  - Raise out_ready: pops yield pc 0x0 then 0x4, in order.
- Full with simultaneous pop: count=2, out_ready=1, in_valid=1 -> pop occurs, push rejected (in_ready=0), count=1 next cycle.
- Flush: count=2 and in_valid=1 with pc=0x10, flush=1.
  - Same cycle: out_valid=0.
  - Next cycle: count=0.
  - Following push of pc=0x40 appears as head one cycle later.
- Wrap-around: 7 alternating push/pop pairs with pc=0x0..0x18 step 4 -> outputs in order with no loss; pointers wrap past DEPTH-1.
